// File: rtl/uart_tx_framer.sv
// uart_tx_framer
// ---------------------------------------------------------------------------
// UART transmit framer. Serialises one DATA_WIDTH-bit word into an
// asynchronous frame: start bit, data bits LSB first, optional even/odd
// parity bit, and one or two stop bits. A one-entry holding register lets
// the next word be queued while a frame is on the line, so queued frames
// leave back-to-back with no idle bit between them. All bit timing comes
// from the external one-cycle baud enable 'tick'.
//
// Optional feature: define UART_TX_BREAK_EN to add the break_req input and
// a BREAK state that holds the line low while break_req is high.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   tick       baud enable, one-cycle pulse per bit period
//   data_in    word to transmit
//   data_valid data_in valid; taken when data_ready=1
//   data_ready holding register empty
//   par_en     insert a parity bit (latched per frame)
//   par_odd    0 = even parity, 1 = odd parity (latched per frame)
//   stop2      1 = two stop bits (latched per frame)
//   break_req  (UART_TX_BREAK_EN only) request a line break
//   tx_out     serial line, idle high, registered
//   busy       frame or break in progress
//   tx_done    one-cycle pulse when the final stop bit ends
// ---------------------------------------------------------------------------
module uart_tx_framer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  output logic                  data_ready,
  input  logic                  par_en,
  input  logic                  par_odd,
  input  logic                  stop2,
`ifdef UART_TX_BREAK_EN
  input  logic                  break_req,
`endif
  output logic                  tx_out,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

`ifdef UART_TX_BREAK_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2, BREAK} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;
`endif

  state_t                  state_reg, state_next;
  logic [DATA_WIDTH-1:0]   hold_reg, hold_next;
  logic                    hold_valid_reg, hold_valid_next;
  logic [DATA_WIDTH-1:0]   shift_reg, shift_next;
  logic [CW-1:0]           bit_cnt_reg, bit_cnt_next;
  logic                    par_en_reg, par_en_next;
  logic                    par_bit_reg, par_bit_next;
  logic                    stop2_reg, stop2_next;
  logic                    tx_reg, tx_next;
  logic                    tx_done_reg, tx_done_next;
  logic                    frame_end;
  logic                    frame_load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      hold_reg       <= '0;
      hold_valid_reg <= 1'b0;
      shift_reg      <= '0;
      bit_cnt_reg    <= '0;
      par_en_reg     <= 1'b0;
      par_bit_reg    <= 1'b0;
      stop2_reg      <= 1'b0;
      tx_reg         <= 1'b1;
      tx_done_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      hold_reg       <= hold_next;
      hold_valid_reg <= hold_valid_next;
      shift_reg      <= shift_next;
      bit_cnt_reg    <= bit_cnt_next;
      par_en_reg     <= par_en_next;
      par_bit_reg    <= par_bit_next;
      stop2_reg      <= stop2_next;
      tx_reg         <= tx_next;
      tx_done_reg    <= tx_done_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    hold_next       = hold_reg;
    hold_valid_next = hold_valid_reg;
    shift_next      = shift_reg;
    bit_cnt_next    = bit_cnt_reg;
    par_en_next     = par_en_reg;
    par_bit_next    = par_bit_reg;
    stop2_next      = stop2_reg;
    tx_next         = tx_reg;
    tx_done_next    = 1'b0;
    frame_end       = 1'b0;
    frame_load      = 1'b0;

    // Accept only into an empty holding register. A frame load needs a full
    // one, so an accept and a load can never collide in the same cycle.
    if (data_valid && !hold_valid_reg) begin
      hold_next       = data_in;
      hold_valid_next = 1'b1;
    end

    if (tick) begin
      case (state_reg)
        IDLE: begin
`ifdef UART_TX_BREAK_EN
          // Break wins over a pending word; the word stays queued.
          if (break_req) begin
            tx_next    = 1'b0;
            state_next = BREAK;
          end else
`endif
          if (hold_valid_reg) begin
            frame_load = 1'b1;
          end
        end
        START: begin
          tx_next      = shift_reg[0];
          bit_cnt_next = '0;
          state_next   = DATA;
        end
        DATA: begin
          if (bit_cnt_reg < LAST_BIT) begin
            shift_next   = shift_reg >> 1;
            tx_next      = shift_reg[1];
            bit_cnt_next = bit_cnt_reg + CW'(1);
          end else if (par_en_reg) begin
            tx_next    = par_bit_reg;
            state_next = PARITY;
          end else begin
            tx_next    = 1'b1;
            state_next = STOP1;
          end
        end
        PARITY: begin
          tx_next    = 1'b1;
          state_next = STOP1;
        end
        STOP1: begin
          if (stop2_reg) begin
            state_next = STOP2;
          end else begin
            frame_end = 1'b1;
          end
        end
        STOP2: begin
          frame_end = 1'b1;
        end
`ifdef UART_TX_BREAK_EN
        BREAK: begin
          if (!break_req) begin
            tx_next    = 1'b1;
            state_next = IDLE;
          end
        end
`endif
        default: begin
          tx_next    = 1'b1;
          state_next = IDLE;
        end
      endcase

      // Last stop bit finished: chain straight into the queued word if there
      // is one, otherwise return the line to idle.
      if (frame_end) begin
        tx_done_next = 1'b1;
        if (hold_valid_reg) begin
          frame_load = 1'b1;
        end else begin
          tx_next    = 1'b1;
          state_next = IDLE;
        end
      end

      // Frame configuration is captured here and nowhere else, so changes on
      // par_en/par_odd/stop2 mid-frame do not disturb the frame in flight.
      if (frame_load) begin
        shift_next      = hold_reg;
        par_en_next     = par_en;
        par_bit_next    = par_odd ? ~^hold_reg : ^hold_reg;
        stop2_next      = stop2;
        hold_valid_next = 1'b0;
        tx_next         = 1'b0;
        state_next      = START;
      end
    end
  end

  assign data_ready = ~hold_valid_reg;
  assign busy       = (state_reg != IDLE);
  assign tx_out     = tx_reg;
  assign tx_done    = tx_done_reg;

endmodule

// File: tb/tb_uart_tx_framer.sv
// tb_uart_tx_framer
// Randomised and directed stimulus for uart_tx_framer. A reference model
// expands each accepted word into its expected line bit sequence and checks
// the line, busy and tx_done at every baud tick.
module tb_uart_tx_framer;

  localparam int DW = 8;
  localparam int TICK_DIV = 16;

  logic          clk;
  logic          rst;
  logic          tick;
  logic [DW-1:0] data_in;
  logic          data_valid;
  logic          data_ready;
  logic          par_en;
  logic          par_odd;
  logic          stop2;
  logic          break_req;
  logic          tx_out;
  logic          busy;
  logic          tx_done;

  uart_tx_framer #(.DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .par_en     (par_en),
    .par_odd    (par_odd),
    .stop2      (stop2),
`ifdef UART_TX_BREAK_EN
    .break_req  (break_req),
`endif
    .tx_out     (tx_out),
    .busy       (busy),
    .tx_done    (tx_done)
  );

  typedef struct {
    logic [DW-1:0] word;
    bit            pe;
    bit            po;
    bit            s2;
    int            acc;
  } entry_t;

  entry_t      exp_q[$];
  entry_t      cur;
  logic [15:0] cur_bits;
  int          cur_len;
  int          pos = -1;
  bit          mon_en = 1'b1;
  int          cyc = 0;
  int          frames_done = 0;
  int          done_pulses = 0;
  int          glitches = 0;
  int          busy_ticks = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  logic        last_tx = 1'b1;
  logic        last_busy = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Expected line bits for one frame, index 0 first on the wire.
  function automatic void build_frame(input entry_t e, output logic [15:0] b, output int len);
    b    = '1;
    b[0] = 1'b0;
    for (int i = 0; i < DW; i++) b[1+i] = e.word[i];
    len = 1 + DW;
    if (e.pe) begin
      // even parity: total ones incl. parity even; odd: total ones odd
      b[len] = (($countones(e.word) % 2) == 1) ? ~e.po : e.po;
      len++;
    end
    b[len] = 1'b1;
    len++;
    if (e.s2) begin
      b[len] = 1'b1;
      len++;
    end
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
    end
  end

  initial begin : tick_gen
    int tcnt;
    tcnt = 0;
    tick = 1'b0;
    forever begin
      @(negedge clk);
      tcnt = (tcnt == TICK_DIV - 1) ? 0 : tcnt + 1;
      tick = (tcnt == 0);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Line monitor and reference-model checker.
  initial begin : monitor
    logic t, r;
    bit   handled, exp_start;
    forever begin
      @(posedge clk);
      t = tick;
      r = rst;
      #1;
      if (r || rst) begin
        last_tx   = tx_out;
        last_busy = busy;
        continue;
      end
      if (tx_done === 1'b1) done_pulses++;
      if (!t) begin
        if (tx_out !== last_tx || busy !== last_busy || tx_done !== 1'b0) glitches++;
      end else begin
        if (busy === 1'b1) busy_ticks++;
        if (mon_en) begin
          handled = 1'b0;
          if (pos >= 0) begin
            if (pos < cur_len) begin
              chk("line_bit", 32'(tx_out), 32'(cur_bits[pos]));
              chk("busy_in_frame", 32'(busy), 32'(1'b1));
              chk("done_in_frame", 32'(tx_done), 32'(1'b0));
              pos++;
              handled = 1'b1;
            end else begin
              chk("done_at_end", 32'(tx_done), 32'(1'b1));
              frames_done++;
              pos = -1;
            end
          end else begin
            chk("done_idle", 32'(tx_done), 32'(1'b0));
          end
          if (!handled) begin
            exp_start = (exp_q.size() > 0) && (exp_q[0].acc < cyc);
            chk("start_or_idle_line", 32'(tx_out), 32'(!exp_start));
            chk("start_or_idle_busy", 32'(busy), 32'(exp_start));
            if (exp_start) begin
              cur = exp_q.pop_front();
              build_frame(cur, cur_bits, cur_len);
              pos = 1;
              $display("frame start word=0x%h pe=%0d po=%0d s2=%0d len=%0d",
                       cur.word, cur.pe, cur.po, cur.s2, cur_len);
            end
          end
        end
      end
      last_tx   = tx_out;
      last_busy = busy;
    end
  end

  // Queue one word: wait for an empty holding register, then present the
  // word and its frame configuration together. data_valid is left high.
  task automatic send(input logic [DW-1:0] w, input bit pe, input bit po, input bit s2);
    entry_t e;
    int n;
    @(negedge clk);
    n = 0;
    while (!data_ready && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (!data_ready) begin
      chk("accept_timeout", 32'(data_ready), 32'(1'b1));
      return;
    end
    data_in    = w;
    par_en     = pe;
    par_odd    = po;
    stop2      = s2;
    data_valid = 1'b1;
    @(posedge clk);
    e.word = w;
    e.pe   = pe;
    e.po   = po;
    e.s2   = s2;
    e.acc  = cyc;
    exp_q.push_back(e);
    @(negedge clk);
    chk("ready_drop", 32'(data_ready), 32'(1'b0));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() > 0 || pos >= 0) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("drain", exp_q.size() + ((pos >= 0) ? 1 : 0), 0);
  endtask

  task automatic wait_tick_edge();
    int n;
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (!tick && n < 100);
    #1;
  endtask

  initial begin : main
    int d0, n;
    rst        = 1'b1;
    data_valid = 1'b0;
    data_in    = '0;
    par_en     = 1'b0;
    par_odd    = 1'b0;
    stop2      = 1'b0;
    break_req  = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_tx_out", 32'(tx_out), 32'(1'b1));
    chk("reset_busy", 32'(busy), 32'(1'b0));
    chk("reset_ready", 32'(data_ready), 32'(1'b1));
    chk("reset_done", 32'(tx_done), 32'(1'b0));
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // 8N1 0xA5
    busy_ticks = 0;
    d0 = done_pulses;
    send(8'hA5, 1'b0, 1'b0, 1'b0);
    data_valid = 1'b0;
    drain();
    chk("busy_ticks_8n1", busy_ticks, 10);
    chk("done_once_8n1", done_pulses - d0, 1);

    // 8E2 then 8O1 with 0x07
    busy_ticks = 0;
    send(8'h07, 1'b1, 1'b0, 1'b1);
    data_valid = 1'b0;
    drain();
    chk("busy_ticks_8e2", busy_ticks, 12);
    busy_ticks = 0;
    send(8'h07, 1'b1, 1'b1, 1'b0);
    data_valid = 1'b0;
    drain();
    chk("busy_ticks_8o1", busy_ticks, 11);

    // Back-to-back 0x55, 0x3C
    busy_ticks = 0;
    send(8'h55, 1'b0, 1'b0, 1'b0);
    send(8'h3C, 1'b0, 1'b0, 1'b0);
    data_valid = 1'b0;
    drain();
    chk("busy_ticks_b2b", busy_ticks, 20);

    // Backpressure: three words with data_valid held high throughout
    for (int i = 0; i < 3; i++) send(DW'($urandom), 1'b0, 1'b0, 1'b0);
    data_valid = 1'b0;
    drain();

    // Randomised words, configurations and gaps
    for (int i = 0; i < 30; i++) begin
      send(DW'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) begin
        data_valid = 1'b0;
        repeat ($urandom_range(0, 60)) @(negedge clk);
      end
    end
    data_valid = 1'b0;
    drain();

    // Reset during data bit 3 with a second word queued
    send(8'hC3, 1'b0, 1'b0, 1'b0);
    send(8'h5A, 1'b0, 1'b0, 1'b0);
    data_valid = 1'b0;
    n = 0;
    while (pos != 5 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("reach_data_bit3", pos, 5);
    #2;
    rst = 1'b1;
    exp_q.delete();
    pos = -1;
    #1;
    chk("async_rst_tx_out", 32'(tx_out), 32'(1'b1));
    chk("async_rst_busy", 32'(busy), 32'(1'b0));
    chk("async_rst_ready", 32'(data_ready), 32'(1'b1));
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (40 * TICK_DIV) @(negedge clk);
    chk("post_rst_idle_tx", 32'(tx_out), 32'(1'b1));
    chk("post_rst_idle_busy", 32'(busy), 32'(1'b0));

`ifdef UART_TX_BREAK_EN
    // Break for 5 ticks while 0xFF is queued
    begin
      entry_t e;
      mon_en = 1'b0;
      wait_tick_edge();
      @(negedge clk);
      break_req  = 1'b1;
      data_in    = 8'hFF;
      par_en     = 1'b0;
      par_odd    = 1'b0;
      stop2      = 1'b0;
      data_valid = 1'b1;
      @(negedge clk);
      data_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
        wait_tick_edge();
        chk("break_line_low", 32'(tx_out), 32'(1'b0));
        chk("break_busy", 32'(busy), 32'(1'b1));
      end
      @(negedge clk);
      break_req = 1'b0;
      wait_tick_edge();
      chk("break_release_line", 32'(tx_out), 32'(1'b1));
      chk("break_release_busy", 32'(busy), 32'(1'b0));
      e.word = 8'hFF;
      e.pe   = 1'b0;
      e.po   = 1'b0;
      e.s2   = 1'b0;
      e.acc  = 0;
      exp_q.push_back(e);
      @(negedge clk);
      mon_en = 1'b1;
      drain();
    end
`endif

    repeat (2 * TICK_DIV) @(negedge clk);
    chk("no_glitches", glitches, 0);
    chk("done_pulse_count", done_pulses, frames_done);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_framer.md
# uart_tx_framer

Parametrised UART transmit framer that serialises one data word into a complete asynchronous frame: start bit, DATA_WIDTH data bits LSB first, optional even/odd parity, and one or two stop bits. A one-entry holding register lets the processor side queue the next word while a frame is on the line, so consecutive frames go out back-to-back with no idle gap. The block is stepped by an external one-cycle baud tick and drives the serial line directly as a registered output.

## Interface
Parameters:
- DATA_WIDTH, 8, data bits per frame (5..9 supported).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- tick  input  1  baud enable; one-cycle pulse per bit period.
- data_in  input  DATA_WIDTH  word to transmit.
- data_valid  input  1  data_in is valid; accepted when data_ready=1.
- data_ready  output  1  holding register empty; can accept a word.
- par_en  input  1  1 = parity bit inserted.
- par_odd  input  1  0 = even parity, 1 = odd parity.
- stop2  input  1  1 = two stop bits, 0 = one stop bit.
- tx_out  output  1  serial line, idle high, registered.
- busy  output  1  frame in progress (state != IDLE).
- tx_done  output  1  one-cycle pulse when the final stop bit ends.

## Operation
- Accept: data_valid && data_ready on a clock edge loads the holding register, sets hold_valid, and drops data_ready on the next cycle. data_valid is ignored while data_ready=0.
- Frame load, on tick, from IDLE, or from the end of the last stop bit, when hold_valid=1:
  - copies the word into the shift register;
  - latches par_en, par_odd and stop2 for the whole frame;
  - computes parity as ^data for even, ~^data for odd;
  - clears hold_valid;
  - sets tx_out<=0;
  - goes to START.
- State transitions. All transitions occur only on cycles with tick=1; without tick, every register holds its value.
  - START -> DATA: tx_out<=bit 0, bit_cnt<=0.
  - DATA:
    - if bit_cnt<DATA_WIDTH-1: shift, tx_out<=next bit, bit_cnt++;
    - otherwise, with parity: tx_out<=parity, -> PARITY;
    - otherwise, without parity: tx_out<=1, -> STOP1.
  - PARITY -> STOP1: tx_out<=1.
  - STOP1:
    - if stop2 is latched: -> STOP2;
    - otherwise: end of frame.
  - STOP2: end of frame.
- End of frame: tx_done<=1 for one cycle. Then:
  - if hold_valid: perform a frame load, giving a back-to-back frame;
  - otherwise: -> IDLE with tx_out=1.
- Bit counter width: clog2(DATA_WIDTH); it never wraps past DATA_WIDTH-1.
- Simultaneous events:
  - an accept and a frame load in the same cycle cannot happen, because data_ready was 0;
  - in the cycle after a load, data_ready=1 and a new word can be accepted while the frame runs.

## Timing
- Reset values:
  - tx_out=1, busy=0, data_ready=1, tx_done=0;
  - state=IDLE, hold_valid=0, bit_cnt=0.
- Reset mid-frame aborts the frame immediately. The line goes high asynchronously and the queued word is discarded.
- Latency:
  - the start bit begins on the first tick edge after acceptance;
  - each bit lasts exactly one tick period;
  - frame length is 1+DATA_WIDTH+par_en+1+stop2 tick periods.
- busy rises in the same edge as the start bit and falls in the same edge that tx_out returns to idle. It stays high across back-to-back frames.
- tx_done is coincident with the start of the next frame's start bit, or with the return to IDLE.
- Config inputs sampled outside a frame load have no effect on the frame in flight.

## Configuration
- UART_TX_BREAK_EN defined:
  - adds input port break_req (1 bit) and state BREAK;
  - in IDLE on tick with break_req=1: tx_out<=0, -> BREAK, which takes priority over a pending frame load;
  - in BREAK on tick with break_req=0: tx_out<=1, -> IDLE;
  - busy=1 in BREAK;
  - accepts into the holding register continue during BREAK;
  - a frame in progress always completes before a break starts.
- UART_TX_BREAK_EN undefined: the break_req port and the BREAK state are absent.

## Test plan
- 8N1: send 0xA5 with tick every 16 clocks. Required:
  - tx_out sequence per tick period is 0,1,0,1,0,0,1,0,1,1;
  - busy is high for 10 tick periods;
  - tx_done pulses once.
- 8E2 then 8O1: send 0x07 with even parity and two stop bits, then 0x07 with odd parity and one stop bit. Required:
  - parity bit 1 then 0;
  - 12 and 11 tick-period frames.
- Back-to-back: send 0x55 and 0x3C, with 0x3C accepted during 0x55. Required:
  - second start bit immediately follows the first stop bit, with no idle period;
  - busy never drops between the frames.
- Backpressure: hold 3 words valid continuously. Required:
  - data_ready=0 while the holding register is full;
  - exactly 3 frames are sent, in order;
  - no word is lost or duplicated.
- Reset mid-frame: assert rst during data bit 3. Required:
  - tx_out=1, busy=0, data_ready=1 immediately, with no clock edge needed;
  - no further frame is sent after release.
- UART_TX_BREAK_EN: break_req high for 5 ticks while 0xFF is queued. Required:
  - tx_out is low for 5 tick periods;
  - the 0xFF frame starts on the tick after release.
